// File: rtl/id_ex_operand_stage_pkg.sv
// Shared pipeline definitions: forwarding select codes, id_ctl bit positions and ALU control codes.
package pipe_defs;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    // id_ctl = {alu_ctr[3:0], src_b_imm, imm_sext, src_a_shamt, src_a_var}
    localparam int CTL_SRC_A_VAR   = 0;
    localparam int CTL_SRC_A_SHAMT = 1;
    localparam int CTL_IMM_SEXT    = 2;
    localparam int CTL_SRC_B_IMM   = 3;
    localparam int CTL_ALU_LSB     = 4;
    localparam int CTL_WIDTH       = 8;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID-side inputs, MEM/WB forwarding tags and EX-side outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
);
    logic               id_valid;
    logic [WIDTH-1:0]   id_pc;
    logic [REGADDR-1:0] id_rs;
    logic [REGADDR-1:0] id_rt;
    logic [REGADDR-1:0] id_rd;
    logic [WIDTH-1:0]   id_rs_data;
    logic [WIDTH-1:0]   id_rt_data;
    logic [15:0]        id_imm;
    logic [4:0]         id_shamt;
    logic [7:0]         id_ctl;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               id_reg_write;
    logic               flush;
    logic               ex_hold;
    logic               mem_reg_write;
    logic [REGADDR-1:0] mem_rd;
    logic [WIDTH-1:0]   mem_result;
    logic               wb_reg_write;
    logic [REGADDR-1:0] wb_rd;
    logic [WIDTH-1:0]   wb_result;

    logic               load_use_stall;
    logic               ex_valid;
    logic [WIDTH-1:0]   ex_alu_a;
    logic [WIDTH-1:0]   ex_alu_b;
    logic [3:0]         ex_alu_ctr;
    logic [WIDTH-1:0]   ex_store_data;
    logic [REGADDR-1:0] ex_rd;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic [WIDTH-1:0]   ex_pc;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_ctl, id_mem_read, id_mem_write, id_reg_write, flush, ex_hold,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        input  load_use_stall, ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctr, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_ctl, id_mem_read, id_mem_write, id_reg_write, flush, ex_hold,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        output load_use_stall, ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctr, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// Bypass selector for one EX source operand: MEM result beats WB result beats the latched value.
module fwd_unit
    import pipe_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic [REGADDR-1:0] src_num,
    input  logic [WIDTH-1:0]   reg_val,
    input  logic               mem_reg_write,
    input  logic [REGADDR-1:0] mem_rd,
    input  logic [WIDTH-1:0]   mem_result,
    input  logic               wb_reg_write,
    input  logic [REGADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0]   wb_result,
    output fwd_sel_t           sel,
    output logic [WIDTH-1:0]   data
);

    // A zero source number short-circuits everything, so a zero-tagged producer can never match.
    always_comb begin
        sel  = FWD_NONE;
        data = reg_val;
        if (src_num == '0) begin
            data = '0;
        end else if (mem_reg_write && (mem_rd == src_num)) begin
            sel  = FWD_MEM;
            data = mem_result;
        end else if (wb_reg_write && (wb_rd == src_num)) begin
            sel  = FWD_WB;
            data = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand select and load-use stall detection.
module id_ex_operand_stage
    import pipe_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic clk,
    input  logic rst,
    id_ex_operand_stage_if.slave bus
);

    logic                 valid_reg;
    logic [WIDTH-1:0]     pc_reg;
    logic [REGADDR-1:0]   rs_num_reg;
    logic [REGADDR-1:0]   rt_num_reg;
    logic [REGADDR-1:0]   rd_reg;
    logic [WIDTH-1:0]     rs_val_reg;
    logic [WIDTH-1:0]     rt_val_reg;
    logic [15:0]          imm_reg;
    logic [4:0]           shamt_reg;
    logic [CTL_WIDTH-1:0] ctl_reg;
    logic                 mem_read_reg;
    logic                 mem_write_reg;
    logic                 reg_write_reg;

    fwd_sel_t             fwd_a_sel;
    fwd_sel_t             fwd_b_sel;
    logic [WIDTH-1:0]     fwd_a;
    logic [WIDTH-1:0]     fwd_b;
    logic                 load_use_stall;
    logic [WIDTH-1:0]     imm_ext;

    fwd_unit #(.WIDTH(WIDTH), .REGADDR(REGADDR)) u_fwd_a (
        .src_num       (rs_num_reg),
        .reg_val       (rs_val_reg),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .mem_result    (bus.mem_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_result     (bus.wb_result),
        .sel           (fwd_a_sel),
        .data          (fwd_a)
    );

    fwd_unit #(.WIDTH(WIDTH), .REGADDR(REGADDR)) u_fwd_b (
        .src_num       (rt_num_reg),
        .reg_val       (rt_val_reg),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .mem_result    (bus.mem_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_result     (bus.wb_result),
        .sel           (fwd_b_sel),
        .data          (fwd_b)
    );

    // A load in EX cannot supply its data until MEM; a flush or downstream hold already freezes ID.
    always_comb begin
        load_use_stall = bus.id_valid && valid_reg && mem_read_reg && (rd_reg != '0) &&
                         ((rd_reg == bus.id_rs) || (rd_reg == bus.id_rt)) &&
                         !bus.flush && !bus.ex_hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            pc_reg        <= '0;
            rs_num_reg    <= '0;
            rt_num_reg    <= '0;
            rd_reg        <= '0;
            rs_val_reg    <= '0;
            rt_val_reg    <= '0;
            imm_reg       <= '0;
            shamt_reg     <= '0;
            ctl_reg       <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (bus.flush || (!bus.ex_hold && load_use_stall)) begin
            valid_reg     <= 1'b0;
            ctl_reg       <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (bus.ex_hold) begin
            // Absorb bypassed values so a producer retiring from WB during the hold is not lost.
            if (fwd_a_sel != FWD_NONE) rs_val_reg <= fwd_a;
            if (fwd_b_sel != FWD_NONE) rt_val_reg <= fwd_b;
        end else begin
            valid_reg     <= bus.id_valid;
            pc_reg        <= bus.id_pc;
            rs_num_reg    <= bus.id_rs;
            rt_num_reg    <= bus.id_rt;
            rd_reg        <= bus.id_rd;
            rs_val_reg    <= bus.id_rs_data;
            rt_val_reg    <= bus.id_rt_data;
            imm_reg       <= bus.id_imm;
            shamt_reg     <= bus.id_shamt;
            ctl_reg       <= bus.id_valid ? bus.id_ctl : '0;
            mem_read_reg  <= bus.id_valid && bus.id_mem_read;
            mem_write_reg <= bus.id_valid && bus.id_mem_write;
            reg_write_reg <= bus.id_valid && bus.id_reg_write;
        end
    end

    always_comb begin
        imm_ext = ctl_reg[CTL_IMM_SEXT] ? {{(WIDTH-16){imm_reg[15]}}, imm_reg}
                                        : {{(WIDTH-16){1'b0}}, imm_reg};
    end

    // Variable shifts take their amount from the register in A, so they override the shamt path.
    assign bus.ex_alu_a       = (ctl_reg[CTL_SRC_A_SHAMT] && !ctl_reg[CTL_SRC_A_VAR])
                                ? {{(WIDTH-5){1'b0}}, shamt_reg} : fwd_a;
    assign bus.ex_alu_b       = ctl_reg[CTL_SRC_B_IMM] ? imm_ext : fwd_b;
    assign bus.ex_alu_ctr     = ctl_reg[CTL_ALU_LSB +: 4];
    assign bus.ex_store_data  = fwd_b;
    assign bus.load_use_stall = load_use_stall;
    assign bus.ex_valid       = valid_reg;
    assign bus.ex_rd          = rd_reg;
    assign bus.ex_reg_write   = reg_write_reg;
    assign bus.ex_mem_read    = mem_read_reg;
    assign bus.ex_mem_write   = mem_write_reg;
    assign bus.ex_pc          = pc_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, forwarding, load-use, flush/hold and immediates.
module tb_id_ex_operand_stage;
    import pipe_defs::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.WIDTH(32), .REGADDR(5)) bus ();

    id_ex_operand_stage #(.WIDTH(32), .REGADDR(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0; bus.id_shamt = '0;
        bus.id_ctl = '0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_reg_write = 0;
        bus.flush = 0; bus.ex_hold = 0;
        bus.mem_reg_write = 0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.wb_reg_write = 0; bus.wb_rd = '0; bus.wb_result = '0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_data, input logic [31:0] rt_data,
                          input logic [7:0] ctl, input logic mem_read, input logic reg_write);
        bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rs_data; bus.id_rt_data = rt_data; bus.id_ctl = ctl;
        bus.id_mem_read = mem_read; bus.id_mem_write = 0; bus.id_reg_write = reg_write;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_alu_ctr !== 4'h0) begin failures++; $display("FAIL reset_ctr got=%h exp=0", bus.ex_alu_ctr); end
        rst = 0;
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_reg_write !== 1'b0) begin failures++; $display("FAIL release_regwr got=%b exp=0", bus.ex_reg_write); end
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL release_stall got=%b exp=0", bus.load_use_stall); end
        $display("test_reset done");
    endtask

    task automatic test_add();
        idle_inputs();
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, {ALU_SUB, 4'b0000}, 0, 1);
        bus.id_pc = 32'h100;
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_alu_a !== 32'd5) begin failures++; $display("FAIL add_a got=%h exp=5", bus.ex_alu_a); end
        checks++; if (bus.ex_alu_b !== 32'd7) begin failures++; $display("FAIL add_b got=%h exp=7", bus.ex_alu_b); end
        checks++; if (bus.ex_rd !== 5'd3) begin failures++; $display("FAIL add_rd got=%0d exp=3", bus.ex_rd); end
        checks++; if (bus.ex_alu_ctr !== ALU_SUB) begin failures++; $display("FAIL add_ctr got=%h exp=%h", bus.ex_alu_ctr, ALU_SUB); end
        checks++; if (bus.ex_pc !== 32'h100) begin failures++; $display("FAIL add_pc got=%h exp=100", bus.ex_pc); end
        checks++; if (bus.ex_reg_write !== 1'b1) begin failures++; $display("FAIL add_regwr got=%b exp=1", bus.ex_reg_write); end
        $display("test_add a=%h b=%h rd=%0d", bus.ex_alu_a, bus.ex_alu_b, bus.ex_rd);
    endtask

    task automatic test_forward();
        idle_inputs();
        set_id(5'd1, 5'd2, 5'd6, 32'hAA, 32'hBB, {ALU_ADD, 4'b0000}, 0, 1);
        tick();
        idle_inputs();
        bus.mem_reg_write = 1; bus.mem_rd = 5'd1; bus.mem_result = 32'h10;
        bus.wb_reg_write = 1;  bus.wb_rd = 5'd1;  bus.wb_result = 32'h20;
        #1;
        checks++; if (bus.ex_alu_a !== 32'h10) begin failures++; $display("FAIL fwd_mem_wins got=%h exp=10", bus.ex_alu_a); end
        bus.mem_rd = 5'd0; bus.mem_result = 32'h99; bus.wb_reg_write = 0;
        #1;
        checks++; if (bus.ex_alu_a !== 32'hAA) begin failures++; $display("FAIL fwd_r0_mem got=%h exp=aa", bus.ex_alu_a); end
        bus.mem_reg_write = 0; bus.wb_reg_write = 1; bus.wb_rd = 5'd2; bus.wb_result = 32'h20;
        #1;
        checks++; if (bus.ex_alu_b !== 32'h20) begin failures++; $display("FAIL fwd_wb_b got=%h exp=20", bus.ex_alu_b); end
        checks++; if (bus.ex_store_data !== 32'h20) begin failures++; $display("FAIL fwd_store got=%h exp=20", bus.ex_store_data); end
        checks++; if (bus.ex_alu_a !== 32'hAA) begin failures++; $display("FAIL fwd_wb_a_untouched got=%h exp=aa", bus.ex_alu_a); end
        $display("test_forward a=%h b=%h", bus.ex_alu_a, bus.ex_alu_b);
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_id(5'd1, 5'd4, 5'd4, 32'h0, 32'h0, {ALU_ADD, 4'b1100}, 1, 1);
        tick();
        set_id(5'd4, 5'd2, 5'd5, 32'h0, 32'd3, {ALU_ADD, 4'b0000}, 0, 1);
        #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.load_use_stall); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble_valid got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_mem_read !== 1'b0) begin failures++; $display("FAIL lu_bubble_memrd got=%b exp=0", bus.ex_mem_read); end
        checks++; if (bus.ex_reg_write !== 1'b0) begin failures++; $display("FAIL lu_bubble_regwr got=%b exp=0", bus.ex_reg_write); end
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL lu_stall_drop got=%b exp=0", bus.load_use_stall); end
        tick();
        bus.wb_reg_write = 1; bus.wb_rd = 5'd4; bus.wb_result = 32'h44;
        #1;
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL lu_use_valid got=%b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_alu_a !== 32'h44) begin failures++; $display("FAIL lu_wb_fwd got=%h exp=44", bus.ex_alu_a); end
        checks++; if (bus.ex_alu_b !== 32'd3) begin failures++; $display("FAIL lu_b got=%h exp=3", bus.ex_alu_b); end
        $display("test_load_use a=%h", bus.ex_alu_a);
    endtask

    task automatic test_flush_hold();
        idle_inputs();
        set_id(5'd1, 5'd4, 5'd4, 32'h0, 32'h0, {ALU_ADD, 4'b1100}, 1, 1);
        tick();
        set_id(5'd4, 5'd0, 5'd5, 32'h0, 32'h0, {ALU_ADD, 4'b0000}, 0, 1);
        bus.ex_hold = 1;
        #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL hold_masks_stall got=%b exp=0", bus.load_use_stall); end
        bus.ex_hold = 0; bus.flush = 1;
        #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL flush_masks_stall got=%b exp=0", bus.load_use_stall); end
        bus.ex_hold = 1;
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_over_hold got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_mem_read !== 1'b0) begin failures++; $display("FAIL flush_memrd got=%b exp=0", bus.ex_mem_read); end
        idle_inputs();
        set_id(5'd1, 5'd2, 5'd7, 32'h1, 32'h11, {ALU_ADD, 4'b0000}, 0, 1);
        tick();
        set_id(5'd8, 5'd9, 5'd10, 32'h0, 32'h0, {ALU_ADD, 4'b0000}, 0, 1);
        bus.ex_hold = 1; bus.wb_reg_write = 1; bus.wb_rd = 5'd2; bus.wb_result = 32'h55;
        tick();
        bus.wb_reg_write = 0;
        tick();
        checks++; if (bus.ex_rd !== 5'd7) begin failures++; $display("FAIL hold_rd got=%0d exp=7", bus.ex_rd); end
        bus.ex_hold = 0;
        #1;
        checks++; if (bus.ex_alu_b !== 32'h55) begin failures++; $display("FAIL hold_wb_capture got=%h exp=55", bus.ex_alu_b); end
        checks++; if (bus.ex_alu_a !== 32'h1) begin failures++; $display("FAIL hold_a got=%h exp=1", bus.ex_alu_a); end
        tick();
        checks++; if (bus.ex_rd !== 5'd10) begin failures++; $display("FAIL release_advance got=%0d exp=10", bus.ex_rd); end
        $display("test_flush_hold done");
    endtask

    task automatic test_imm_back_to_back();
        idle_inputs();
        bus.id_shamt = 5'd3;
        set_id(5'd0, 5'd2, 5'd3, 32'h0, 32'h1, {ALU_SLL, 4'b0010}, 0, 1);
        tick();
        bus.id_imm = 16'hFFFF;
        set_id(5'd1, 5'd0, 5'd3, 32'h0, 32'h0, {ALU_ADD, 4'b1100}, 0, 1);
        #1;
        checks++; if (bus.ex_alu_a !== 32'd3) begin failures++; $display("FAIL sll_a got=%h exp=3", bus.ex_alu_a); end
        checks++; if (bus.ex_alu_b !== 32'd1) begin failures++; $display("FAIL sll_b got=%h exp=1", bus.ex_alu_b); end
        checks++; if (bus.ex_alu_ctr !== ALU_SLL) begin failures++; $display("FAIL sll_ctr got=%h exp=%h", bus.ex_alu_ctr, ALU_SLL); end
        tick();
        set_id(5'd1, 5'd0, 5'd3, 32'h0, 32'h0, {ALU_OR, 4'b1000}, 0, 1);
        #1;
        checks++; if (bus.ex_alu_b !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_sext got=%h exp=ffffffff", bus.ex_alu_b); end
        tick();
        checks++; if (bus.ex_alu_b !== 32'h0000FFFF) begin failures++; $display("FAIL ori_zext got=%h exp=0000ffff", bus.ex_alu_b); end
        checks++; if (bus.ex_alu_ctr !== ALU_OR) begin failures++; $display("FAIL ori_ctr got=%h exp=%h", bus.ex_alu_ctr, ALU_OR); end
        $display("test_imm_back_to_back b=%h", bus.ex_alu_b);
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        set_id(5'd1, 5'd4, 5'd4, 32'h0, 32'h0, {ALU_ADD, 4'b1100}, 1, 1);
        tick();
        set_id(5'd4, 5'd0, 5'd5, 32'h0, 32'h0, {ALU_ADD, 4'b0000}, 0, 1);
        #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", bus.load_use_stall); end
        rst = 1;
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.load_use_stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", bus.load_use_stall); end
        tick();
        rst = 0;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_load_use();
        test_flush_hold();
        test_imm_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
